axi4_slave_mem: RTL and testbench
=================================

Name: axi4_slave_mem

Overview:
- AXI4 slave responder with on-chip word memory; the target-side counterpart of the NoC master port (M1-style AW/W/B/AR/R channels, 32-bit data, 4-bit LEN).
- Used as the slave endpoint behind the NoC so master traffic can be terminated in simulation and on FPGA.
- Write and read paths are independent FSMs sharing one memory array.

Parameters:
- DEPTH, 256, memory depth in 32-bit words (power of 2); byte address range 0 to DEPTH*4-1.
- BASE_ADDR, 32'h0000_0000, address decoded as in-range when BASE_ADDR <= addr < BASE_ADDR+DEPTH*4.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  async active-low reset
- S_AWID in 4, S_AWADDR in 32, S_AWLEN in 4, S_AWSIZE in 3, S_AWBURST in 2, S_AWVALID in 1  write address channel
- S_AWREADY  out  1  write address accepted
- S_WDATA in 32, S_WSTRB in 4, S_WLAST in 1, S_WVALID in 1  write data channel
- S_WREADY  out  1  write data accepted
- S_BID out 4, S_BRESP out 2, S_BVALID out 1  write response
- S_BREADY  in  1  master accepts response
- S_ARID in 4, S_ARADDR in 32, S_ARLEN in 4, S_ARSIZE in 3, S_ARBURST in 2, S_ARVALID in 1  read address channel
- S_ARREADY  out  1  read address accepted
- S_RID out 4, S_RDATA out 32, S_RRESP out 2, S_RLAST out 1, S_RVALID out 1  read data channel
- S_RREADY  in  1  master accepts read beat

Behaviour:
- Reset (ARESETn low, async): AWREADY=1, ARREADY=1; WREADY, BVALID, RVALID, RLAST=0; BID, BRESP, RID, RRESP, RDATA=0. Memory contents are not reset. Reset mid-burst aborts the burst silently; completed beats stay written.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, capture ID/ADDR/LEN/SIZE/BURST, clear beat counter and error flag, go W_DATA (AWREADY=0, WREADY=1 next cycle).
  - W_DATA: each WVALID&WREADY writes only the bytes with WSTRB[i]=1, then advances the address.
  - Burn-off: after beat LEN+1, go W_RESP with WREADY=0; BVALID=1 the cycle after the last beat.
  - W_RESP: hold BID=captured AWID and BRESP until BREADY; then BVALID=0, AWREADY=1.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On handshake, capture fields; RVALID=1 with beat 0 on the next cycle.
  - R_DATA: beat held stable until RREADY; RLAST=1 only on beat ARLEN; after the last handshake RVALID=0, ARREADY=1.
- Address sequencing (4-byte beats):
  - FIXED (00): same address every beat.
  - INCR (01): +4 per beat.
  - WRAP (10): wraps at a boundary of (LEN+1)*4 bytes, aligned down; e.g. start 0x1C, LEN=3 gives 0x1C, 0x10, 0x14, 0x18.
- Error rules (SLVERR=2'b10; otherwise OKAY=2'b00):
  - Any of the following makes the beat an error: SIZE != 3'b010, BURST=11, WRAP with LEN not in {1,3,7,15}, beat address out of range.
  - Error write beats: accepted, memory not modified.
  - Error read beats: RDATA=0, RRESP=SLVERR.
  - BRESP=SLVERR if any beat of the burst erred.
  - WLAST mismatch (WLAST=1 before beat LEN, or 0 on beat LEN) gives BRESP=SLVERR; the burst length is still set by LEN.
- Addressing: word index = (addr-BASE_ADDR)[log2(DEPTH)+1:2]; low two address bits ignored.
- Simultaneous read and write of the same word in one cycle: the read returns the old data and the write takes effect next cycle.
- RDATA is registered from memory; a read issued the cycle after a write handshake to the same word returns the new data.
- Master behaviours the slave must handle:
  - W beats arriving before the AW handshake are not accepted (WREADY=0 in W_IDLE).
  - BREADY held low stalls the write FSM indefinitely.
  - RREADY low stalls the read FSM indefinitely.

Test Plan:
- Single write AWADDR=0x10, LEN=0, WDATA=0xDEADBEEF, WSTRB=4'hF, then read 0x10 -> BRESP=00, BID=AWID; RDATA=0xDEADBEEF, RLAST=1, RRESP=00.
- INCR write LEN=3 at 0x40 with data 1..4, WSTRB=4'b0011 on beat 2 over a prior 0xFFFFFFFF -> read back 1, 2, 0xFFFF0003, 4; RLAST only on beat 3.
- WRAP read LEN=3 at 0x1C after preloading 0x10..0x1C with A, B, C, D -> RDATA sequence D, A, B, C.
- Out-of-range write to BASE_ADDR+DEPTH*4 -> BRESP=10, memory unchanged; read of the same address -> RDATA=0, RRESP=10.
- Backpressure: BREADY held low 5 cycles and RREADY toggled every other cycle on a LEN=7 read -> BVALID/BID stable until accepted; each RDATA held until its handshake; exactly 8 beats.
- ARESETn pulsed low during beat 2 of a LEN=7 write -> all outputs at reset values asynchronously; beats 0-1 persist; a new write after reset completes with BRESP=00.

Source files
------------

// File: rtl/axi4_slave_mem_if.sv
// AXI4 channel bundle (AW/W/B/AR/R) between a NoC master port and the slave memory.
// Clock and reset stay plain ports on the modules that use this bundle.
interface axi4_slave_mem_if;
  logic [3:0]  S_AWID;
  logic [31:0] S_AWADDR;
  logic [3:0]  S_AWLEN;
  logic [2:0]  S_AWSIZE;
  logic [1:0]  S_AWBURST;
  logic        S_AWVALID;
  logic        S_AWREADY;
  logic [31:0] S_WDATA;
  logic [3:0]  S_WSTRB;
  logic        S_WLAST;
  logic        S_WVALID;
  logic        S_WREADY;
  logic [3:0]  S_BID;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY;
  logic [3:0]  S_ARID;
  logic [31:0] S_ARADDR;
  logic [3:0]  S_ARLEN;
  logic [2:0]  S_ARSIZE;
  logic [1:0]  S_ARBURST;
  logic        S_ARVALID;
  logic        S_ARREADY;
  logic [3:0]  S_RID;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RLAST;
  logic        S_RVALID;
  logic        S_RREADY;

  modport slave (
    input  S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
    input  S_WDATA, S_WSTRB, S_WLAST, S_WVALID, S_BREADY,
    input  S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
    output S_AWREADY, S_WREADY, S_BID, S_BRESP, S_BVALID,
    output S_ARREADY, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID
  );

  modport master (
    output S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
    output S_WDATA, S_WSTRB, S_WLAST, S_WVALID, S_BREADY,
    output S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_RREADY,
    input  S_AWREADY, S_WREADY, S_BID, S_BRESP, S_BVALID,
    input  S_ARREADY, S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID
  );
endinterface

// File: rtl/axi4_slave_mem.sv
// AXI4 slave terminating NoC traffic into a word memory; independent write and read
// FSMs share the array. Erroneous beats are answered with SLVERR and never touch memory.
module axi4_slave_mem #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic ACLK,
  input logic ARESETn,
  axi4_slave_mem_if.slave s
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [3:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (size != 3'b010) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  function automatic logic in_range(input logic [31:0] addr);
    return (addr >= BASE_ADDR) && ((addr - BASE_ADDR) < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  // WRAP keeps the upper bits of the (LEN+1)*4-byte aligned window and rolls the low bits.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                            input logic [3:0] len);
    logic [31:0] mask;
    logic [31:0] nxt;
    mask = (({28'd0, len} + 32'd1) << 2) - 32'd1;
    case (burst)
      2'b00:   nxt = addr;
      2'b10:   nxt = (addr & ~mask) | ((addr + 32'd4) & mask);
      default: nxt = addr + 32'd4;
    endcase
    return nxt;
  endfunction

  logic [31:0] mem [DEPTH];

  w_state_e    w_state_q, w_state_d;
  logic [3:0]  aw_id_q, aw_id_d, aw_len_q, aw_len_d, w_cnt_q, w_cnt_d;
  logic [2:0]  aw_size_q, aw_size_d;
  logic [1:0]  aw_burst_q, aw_burst_d, bresp_q, bresp_d;
  logic [31:0] w_addr_q, w_addr_d;
  logic        w_err_q, w_err_d;
  logic        w_beat_s, w_last_s, w_beat_err_s, w_any_err_s;

  r_state_e    r_state_q, r_state_d;
  logic [3:0]  ar_id_q, ar_id_d, ar_len_q, ar_len_d, r_cnt_q, r_cnt_d;
  logic [2:0]  ar_size_q, ar_size_d;
  logic [1:0]  ar_burst_q, ar_burst_d, rresp_q, rresp_d;
  logic [31:0] r_addr_q, r_addr_d, rdata_q, rdata_d, fetch_addr_s;
  logic        rlast_q, rlast_d, fetch_en_s, fetch_bad_s, fetch_err_s;

  // Write FSM state and burst context registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= 4'd0;
      aw_len_q   <= 4'd0;
      aw_size_q  <= 3'd0;
      aw_burst_q <= 2'd0;
      w_addr_q   <= 32'd0;
      w_cnt_q    <= 4'd0;
      w_err_q    <= 1'b0;
      bresp_q    <= 2'b00;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_addr_q   <= w_addr_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      bresp_q    <= bresp_d;
    end
  end

  assign w_beat_s     = s.S_WVALID && (w_state_q == W_DATA);
  assign w_last_s     = (w_cnt_q == aw_len_q);
  assign w_beat_err_s = burst_bad(aw_size_q, aw_burst_q, aw_len_q) || !in_range(w_addr_q);
  assign w_any_err_s  = w_err_q || w_beat_err_s || (s.S_WLAST != w_last_s);

  // Write next-state: burst length comes from LEN; WLAST only feeds the error flag.
  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_addr_d   = w_addr_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    bresp_d    = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (s.S_AWVALID) begin
          aw_id_d    = s.S_AWID;
          aw_len_d   = s.S_AWLEN;
          aw_size_d  = s.S_AWSIZE;
          aw_burst_d = s.S_AWBURST;
          w_addr_d   = s.S_AWADDR;
          w_cnt_d    = 4'd0;
          w_err_d    = 1'b0;
          w_state_d  = W_DATA;
        end else begin
          w_state_d  = W_IDLE;
        end
      end
      W_DATA: begin
        if (w_beat_s) begin
          w_err_d  = w_any_err_s;
          w_addr_d = next_addr(w_addr_q, aw_burst_q, aw_len_q);
          w_cnt_d  = w_cnt_q + 4'd1;
          if (w_last_s) begin
            w_state_d = W_RESP;
            bresp_d   = w_any_err_s ? 2'b10 : 2'b00;
          end else begin
            w_state_d = W_DATA;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (s.S_BREADY) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write outputs decoded from the state register.
  always_comb begin
    s.S_AWREADY = (w_state_q == W_IDLE);
    s.S_WREADY  = (w_state_q == W_DATA);
    s.S_BVALID  = (w_state_q == W_RESP);
    s.S_BID     = aw_id_q;
    s.S_BRESP   = bresp_q;
  end

  // Byte-masked memory write; contents deliberately survive reset.
  always_ff @(posedge ACLK) begin
    if (w_beat_s && !w_beat_err_s) begin
      for (int i = 0; i < 4; i++) begin
        if (s.S_WSTRB[i]) begin
          mem[word_idx(w_addr_q)][8*i +: 8] <= s.S_WDATA[8*i +: 8];
        end
      end
    end
  end

  // Read FSM state, burst context and registered beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= 4'd0;
      ar_len_q   <= 4'd0;
      ar_size_q  <= 3'd0;
      ar_burst_q <= 2'd0;
      r_addr_q   <= 32'd0;
      r_cnt_q    <= 4'd0;
      rdata_q    <= 32'd0;
      rresp_q    <= 2'b00;
      rlast_q    <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_addr_q   <= r_addr_d;
      r_cnt_q    <= r_cnt_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end

  // Read next-state: memory is sampled here before any same-edge write lands.
  always_comb begin
    r_state_d    = r_state_q;
    ar_id_d      = ar_id_q;
    ar_len_d     = ar_len_q;
    ar_size_d    = ar_size_q;
    ar_burst_d   = ar_burst_q;
    r_addr_d     = r_addr_q;
    r_cnt_d      = r_cnt_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    rlast_d      = rlast_q;
    fetch_en_s   = 1'b0;
    fetch_addr_s = r_addr_q;
    fetch_bad_s  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (s.S_ARVALID) begin
          ar_id_d      = s.S_ARID;
          ar_len_d     = s.S_ARLEN;
          ar_size_d    = s.S_ARSIZE;
          ar_burst_d   = s.S_ARBURST;
          r_addr_d     = s.S_ARADDR;
          r_cnt_d      = 4'd0;
          rlast_d      = (s.S_ARLEN == 4'd0);
          fetch_en_s   = 1'b1;
          fetch_addr_s = s.S_ARADDR;
          fetch_bad_s  = burst_bad(s.S_ARSIZE, s.S_ARBURST, s.S_ARLEN);
          r_state_d    = R_DATA;
        end else begin
          r_state_d    = R_IDLE;
        end
      end
      R_DATA: begin
        if (s.S_RREADY && (r_cnt_q == ar_len_q)) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else if (s.S_RREADY) begin
          fetch_en_s   = 1'b1;
          fetch_addr_s = next_addr(r_addr_q, ar_burst_q, ar_len_q);
          fetch_bad_s  = burst_bad(ar_size_q, ar_burst_q, ar_len_q);
          r_addr_d     = fetch_addr_s;
          r_cnt_d      = r_cnt_q + 4'd1;
          rlast_d      = ((r_cnt_q + 4'd1) == ar_len_q);
          r_state_d    = R_DATA;
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    fetch_err_s = fetch_bad_s || !in_range(fetch_addr_s);
    if (fetch_en_s) begin
      rdata_d = fetch_err_s ? 32'd0 : mem[word_idx(fetch_addr_s)];
      rresp_d = fetch_err_s ? 2'b10 : 2'b00;
    end else begin
      rdata_d = rdata_q;
      rresp_d = rresp_q;
    end
  end

  // Read outputs decoded from the state and beat registers.
  always_comb begin
    s.S_ARREADY = (r_state_q == R_IDLE);
    s.S_RVALID  = (r_state_q == R_DATA);
    s.S_RID     = ar_id_q;
    s.S_RDATA   = rdata_q;
    s.S_RRESP   = rresp_q;
    s.S_RLAST   = rlast_q;
  end
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: each task drives one scenario and checks inline
// against hand-computed values. Inputs change and outputs are sampled on the falling edge.
module tb_axi4_slave_mem;
  logic ACLK;
  logic ARESETn;
  int tests_run    = 0;
  int tests_failed = 0;

  axi4_slave_mem_if bus ();

  axi4_slave_mem #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s       (bus.slave)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  localparam logic [49:0] RST_VEC = {6'b100100, 44'd0};

  logic [3:0]  wr_bid;
  logic [1:0]  wr_bresp;
  bit          wr_tmo;
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id;
  int          rd_beats, rd_unstable;
  bit          rd_tmo;

  function automatic logic [49:0] out_vec();
    return {bus.S_AWREADY, bus.S_WREADY, bus.S_BVALID, bus.S_ARREADY, bus.S_RVALID,
            bus.S_RLAST, bus.S_BID, bus.S_BRESP, bus.S_RID, bus.S_RRESP, bus.S_RDATA};
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input logic [31:0] base, input logic [31:0] step,
                          input logic [3:0] strb2, input bit early_last, input bit take_resp);
    int n;
    wr_tmo = 1'b0;
    @(negedge ACLK);
    bus.S_AWID = id; bus.S_AWADDR = addr; bus.S_AWLEN = len;
    bus.S_AWSIZE = size; bus.S_AWBURST = burst; bus.S_AWVALID = 1'b1;
    n = 0;
    while (bus.S_AWREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) wr_tmo = 1'b1;
    @(negedge ACLK);
    bus.S_AWVALID = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      bus.S_WDATA  = base + step * 32'(b);
      bus.S_WSTRB  = (b == 2) ? strb2 : 4'hF;
      bus.S_WLAST  = early_last ? 1'b1 : (b == int'(len));
      bus.S_WVALID = 1'b1;
      n = 0;
      while (bus.S_WREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
      if (n >= 50) wr_tmo = 1'b1;
      @(negedge ACLK);
    end
    bus.S_WVALID = 1'b0;
    bus.S_WLAST  = 1'b0;
    if (take_resp) begin
      bus.S_BREADY = 1'b1;
      n = 0;
      while (bus.S_BVALID !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
      if (n >= 50) wr_tmo = 1'b1;
      wr_bid   = bus.S_BID;
      wr_bresp = bus.S_BRESP;
      @(negedge ACLK);
      bus.S_BREADY = 1'b0;
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input bit toggle);
    int n, cyc;
    bit held;
    logic [31:0] hd;
    rd_beats = 0; rd_unstable = 0; rd_tmo = 1'b0; held = 1'b0; hd = 32'd0;
    @(negedge ACLK);
    bus.S_ARID = id; bus.S_ARADDR = addr; bus.S_ARLEN = len;
    bus.S_ARSIZE = 3'b010; bus.S_ARBURST = burst; bus.S_ARVALID = 1'b1;
    n = 0;
    while (bus.S_ARREADY !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    if (n >= 50) rd_tmo = 1'b1;
    @(negedge ACLK);
    bus.S_ARVALID = 1'b0;
    cyc = 0;
    while (rd_beats < int'(len) + 1 && cyc < 200) begin
      bus.S_RREADY = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (bus.S_RVALID === 1'b1) begin
        if (held && bus.S_RDATA !== hd) rd_unstable++;
        if (bus.S_RREADY) begin
          if (rd_beats == 0) rd_id = bus.S_RID;
          rd_data[rd_beats] = bus.S_RDATA;
          rd_resp[rd_beats] = bus.S_RRESP;
          rd_last[rd_beats] = bus.S_RLAST;
          rd_beats++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = bus.S_RDATA;
        end
      end
      @(negedge ACLK);
      cyc++;
    end
    if (cyc >= 200) rd_tmo = 1'b1;
    bus.S_RREADY = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    tests_run++;
    if (out_vec() !== RST_VEC) begin
      tests_failed++;
      $display("FAIL reset_values: got %h, want %h", out_vec(), RST_VEC);
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  task automatic test_single();
    do_write(4'd3, 32'h10, 4'd0, 2'b01, 3'b010, 32'hDEADBEEF, 32'd0, 4'hF, 1'b0, 1'b1);
    tests_run++;
    if ({wr_tmo, wr_bid, wr_bresp} !== {1'b0, 4'd3, 2'b00}) begin
      tests_failed++;
      $display("FAIL single_bresp: tmo/bid/bresp got %b/%h/%b, want 0/3/00", wr_tmo, wr_bid, wr_bresp);
    end
    do_read(4'd5, 32'h10, 4'd0, 2'b01, 1'b0);
    tests_run++;
    if ({rd_tmo, rd_id, rd_data[0], rd_resp[0], rd_last[0]} !== {1'b0, 4'd5, 32'hDEADBEEF, 2'b00, 1'b1}) begin
      tests_failed++;
      $display("FAIL single_read: tmo/id/data/resp/last got %b/%h/%h/%b/%b, want 0/5/deadbeef/00/1",
               rd_tmo, rd_id, rd_data[0], rd_resp[0], rd_last[0]);
    end
  endtask

  task automatic test_incr_strb();
    logic [31:0] exp [4];
    exp[0] = 32'd1; exp[1] = 32'd2; exp[2] = 32'hFFFF0003; exp[3] = 32'd4;
    do_write(4'd1, 32'h40, 4'd3, 2'b01, 3'b010, 32'hFFFFFFFF, 32'd0, 4'hF, 1'b0, 1'b1);
    do_write(4'd2, 32'h40, 4'd3, 2'b01, 3'b010, 32'd1, 32'd1, 4'b0011, 1'b0, 1'b1);
    tests_run++;
    if ({wr_tmo, wr_bresp} !== 3'b000) begin
      tests_failed++;
      $display("FAIL incr_bresp: tmo/bresp got %b/%b, want 0/00", wr_tmo, wr_bresp);
    end
    do_read(4'd2, 32'h40, 4'd3, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if ({rd_data[i], rd_last[i]} !== {exp[i], (i == 3)}) begin
        tests_failed++;
        $display("FAIL incr_beat%0d: data/last got %h/%b, want %h/%b", i, rd_data[i], rd_last[i], exp[i], (i == 3));
      end
    end
  endtask

  task automatic test_wrap_read();
    logic [31:0] e;
    do_write(4'd4, 32'h10, 4'd3, 2'b01, 3'b010, 32'hA, 32'd1, 4'hF, 1'b0, 1'b1);
    do_read(4'd4, 32'h1C, 4'd3, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      e = 32'hA + 32'((i + 3) % 4);
      tests_run++;
      if ({rd_tmo, rd_data[i], rd_resp[i]} !== {1'b0, e, 2'b00}) begin
        tests_failed++;
        $display("FAIL wrap_beat%0d: tmo/data/resp got %b/%h/%b, want 0/%h/00", i, rd_tmo, rd_data[i], rd_resp[i], e);
      end
    end
  endtask

  task automatic test_out_of_range();
    do_write(4'd7, 32'h0, 4'd0, 2'b01, 3'b010, 32'h55AA55AA, 32'd0, 4'hF, 1'b0, 1'b1);
    do_write(4'd7, 32'h400, 4'd0, 2'b01, 3'b010, 32'h12345678, 32'd0, 4'hF, 1'b0, 1'b1);
    tests_run++;
    if ({wr_bid, wr_bresp} !== {4'd7, 2'b10}) begin
      tests_failed++;
      $display("FAIL oor_bresp: bid/bresp got %h/%b, want 7/10", wr_bid, wr_bresp);
    end
    do_read(4'd8, 32'h0, 4'd0, 2'b01, 1'b0);
    tests_run++;
    if (rd_data[0] !== 32'h55AA55AA) begin
      tests_failed++;
      $display("FAIL oor_mem_unchanged: got %h, want 55aa55aa", rd_data[0]);
    end
    do_read(4'd8, 32'h400, 4'd0, 2'b01, 1'b0);
    tests_run++;
    if ({rd_data[0], rd_resp[0]} !== {32'd0, 2'b10}) begin
      tests_failed++;
      $display("FAIL oor_read: data/resp got %h/%b, want 0/10", rd_data[0], rd_resp[0]);
    end
  endtask

  task automatic test_errors();
    do_write(4'd1, 32'h60, 4'd0, 2'b01, 3'b001, 32'h1, 32'd0, 4'hF, 1'b0, 1'b1);
    tests_run++;
    if (wr_bresp !== 2'b10) begin
      tests_failed++;
      $display("FAIL err_size: bresp got %b, want 10", wr_bresp);
    end
    do_write(4'd1, 32'h64, 4'd1, 2'b01, 3'b010, 32'h1, 32'd1, 4'hF, 1'b1, 1'b1);
    tests_run++;
    if ({wr_tmo, wr_bresp} !== 3'b010) begin
      tests_failed++;
      $display("FAIL err_early_wlast: tmo/bresp got %b/%b, want 0/10", wr_tmo, wr_bresp);
    end
    do_read(4'd1, 32'h10, 4'd0, 2'b11, 1'b0);
    tests_run++;
    if ({rd_data[0], rd_resp[0]} !== {32'd0, 2'b10}) begin
      tests_failed++;
      $display("FAIL err_burst11: data/resp got %h/%b, want 0/10", rd_data[0], rd_resp[0]);
    end
  endtask

  task automatic test_backpressure();
    do_write(4'd9, 32'h80, 4'd0, 2'b01, 3'b010, 32'h5, 32'd0, 4'hF, 1'b0, 1'b0);
    bus.S_BREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if ({bus.S_BVALID, bus.S_BID} !== {1'b1, 4'd9}) begin
        tests_failed++;
        $display("FAIL bp_bstall%0d: bvalid/bid got %b/%h, want 1/9", i, bus.S_BVALID, bus.S_BID);
      end
      @(negedge ACLK);
    end
    bus.S_BREADY = 1'b1;
    @(negedge ACLK);
    bus.S_BREADY = 1'b0;
    tests_run++;
    if ({bus.S_BVALID, bus.S_AWREADY} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_bdone: bvalid/awready got %b/%b, want 0/1", bus.S_BVALID, bus.S_AWREADY);
    end
    do_write(4'd2, 32'h40, 4'd7, 2'b01, 3'b010, 32'h100, 32'd1, 4'hF, 1'b0, 1'b1);
    do_read(4'd6, 32'h40, 4'd7, 2'b01, 1'b1);
    tests_run++;
    if ({rd_tmo, rd_unstable, rd_beats} !== {1'b0, 32'd0, 32'd8}) begin
      tests_failed++;
      $display("FAIL bp_rstall: tmo/unstable/beats got %b/%0d/%0d, want 0/0/8", rd_tmo, rd_unstable, rd_beats);
    end
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if ({rd_data[i], rd_last[i]} !== {32'h100 + 32'(i), (i == 7)}) begin
        tests_failed++;
        $display("FAIL bp_beat%0d: data/last got %h/%b, want %h/%b", i, rd_data[i], rd_last[i], 32'h100 + 32'(i), (i == 7));
      end
    end
    tests_run++;
    if ({bus.S_RVALID, bus.S_ARREADY} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_rdone: rvalid/arready got %b/%b, want 0/1", bus.S_RVALID, bus.S_ARREADY);
    end
  endtask

  task automatic test_reset_mid_burst();
    @(negedge ACLK);
    bus.S_AWID = 4'd6; bus.S_AWADDR = 32'h200; bus.S_AWLEN = 4'd7;
    bus.S_AWSIZE = 3'b010; bus.S_AWBURST = 2'b01; bus.S_AWVALID = 1'b1;
    @(negedge ACLK);
    bus.S_AWVALID = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.S_WDATA = 32'h7000 + 32'(b); bus.S_WSTRB = 4'hF; bus.S_WLAST = 1'b0; bus.S_WVALID = 1'b1;
      @(negedge ACLK);
    end
    bus.S_WDATA = 32'h7002;
    #2 ARESETn = 1'b0;
    #1;
    tests_run++;
    if (out_vec() !== RST_VEC) begin
      tests_failed++;
      $display("FAIL midburst_async_reset: got %h, want %h", out_vec(), RST_VEC);
    end
    @(negedge ACLK);
    bus.S_WVALID = 1'b0;
    ARESETn = 1'b1;
    do_read(4'd3, 32'h200, 4'd1, 2'b01, 1'b0);
    tests_run++;
    if ({rd_tmo, rd_data[0], rd_data[1]} !== {1'b0, 32'h7000, 32'h7001}) begin
      tests_failed++;
      $display("FAIL midburst_persist: tmo/d0/d1 got %b/%h/%h, want 0/7000/7001", rd_tmo, rd_data[0], rd_data[1]);
    end
    do_write(4'd4, 32'h300, 4'd1, 2'b01, 3'b010, 32'h9, 32'd1, 4'hF, 1'b0, 1'b1);
    tests_run++;
    if ({wr_tmo, wr_bid, wr_bresp} !== {1'b0, 4'd4, 2'b00}) begin
      tests_failed++;
      $display("FAIL midburst_new_write: tmo/bid/bresp got %b/%h/%b, want 0/4/00", wr_tmo, wr_bid, wr_bresp);
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    bus.S_AWID = 4'd0; bus.S_AWADDR = 32'd0; bus.S_AWLEN = 4'd0; bus.S_AWSIZE = 3'd0;
    bus.S_AWBURST = 2'd0; bus.S_AWVALID = 1'b0;
    bus.S_WDATA = 32'd0; bus.S_WSTRB = 4'd0; bus.S_WLAST = 1'b0; bus.S_WVALID = 1'b0;
    bus.S_BREADY = 1'b0;
    bus.S_ARID = 4'd0; bus.S_ARADDR = 32'd0; bus.S_ARLEN = 4'd0; bus.S_ARSIZE = 3'd0;
    bus.S_ARBURST = 2'd0; bus.S_ARVALID = 1'b0; bus.S_RREADY = 1'b0;
    test_reset();
    test_single();
    test_incr_strb();
    test_wrap_read();
    test_out_of_range();
    test_errors();
    test_backpressure();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
